// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment shift-register link:
// segment patterns, default digit selects, frame length and receiver states.
package seven_seg_pkg;

    localparam int FRAME_LEN = 16;
    localparam logic [3:0] FRAME_LAST = 4'(FRAME_LEN - 1);

    localparam logic [7:0] DEF_ONES_SEL = 8'h40;
    localparam logic [7:0] DEF_TENS_SEL = 8'h20;

    localparam logic [7:0] SEG_0 = 8'hEE;
    localparam logic [7:0] SEG_1 = 8'h48;
    localparam logic [7:0] SEG_2 = 8'h3E;
    localparam logic [7:0] SEG_3 = 8'h7C;
    localparam logic [7:0] SEG_4 = 8'hD8;
    localparam logic [7:0] SEG_5 = 8'hF4;
    localparam logic [7:0] SEG_6 = 8'hF6;
    localparam logic [7:0] SEG_7 = 8'h68;
    localparam logic [7:0] SEG_8 = 8'hFE;
    localparam logic [7:0] SEG_9 = 8'hFC;
    localparam logic [7:0] SEG_A = 8'hFA;
    localparam logic [7:0] SEG_B = 8'hD6;
    localparam logic [7:0] SEG_C = 8'hA6;
    localparam logic [7:0] SEG_D = 8'h5E;
    localparam logic [7:0] SEG_E = 8'hB6;
    localparam logic [7:0] SEG_F = 8'hB2;

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } rx_state_t;

    // Nibble to segment pattern, used by the driver side of the link.
    function automatic logic [7:0] seg_encode(input logic [3:0] nib);
        logic [7:0] pat;
        case (nib)
            4'h0: pat = SEG_0;
            4'h1: pat = SEG_1;
            4'h2: pat = SEG_2;
            4'h3: pat = SEG_3;
            4'h4: pat = SEG_4;
            4'h5: pat = SEG_5;
            4'h6: pat = SEG_6;
            4'h7: pat = SEG_7;
            4'h8: pat = SEG_8;
            4'h9: pat = SEG_9;
            4'hA: pat = SEG_A;
            4'hB: pat = SEG_B;
            4'hC: pat = SEG_C;
            4'hD: pat = SEG_D;
            4'hE: pat = SEG_E;
            default: pat = SEG_F;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational segment-pattern to hex-nibble decoder. Unknown patterns
// return nibble 0 with ok low.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [7:0] pattern,
    output logic [3:0] nibble,
    output logic       ok
);

    // Reverse lookup of the segment table; all 16 patterns are distinct.
    always_comb begin
        nibble = 4'h0;
        ok     = 1'b1;
        case (pattern)
            SEG_0: nibble = 4'h0;
            SEG_1: nibble = 4'h1;
            SEG_2: nibble = 4'h2;
            SEG_3: nibble = 4'h3;
            SEG_4: nibble = 4'h4;
            SEG_5: nibble = 4'h5;
            SEG_6: nibble = 4'h6;
            SEG_7: nibble = 4'h7;
            SEG_8: nibble = 4'h8;
            SEG_9: nibble = 4'h9;
            SEG_A: nibble = 4'hA;
            SEG_B: nibble = 4'hB;
            SEG_C: nibble = 4'hC;
            SEG_D: nibble = 4'hD;
            SEG_E: nibble = 4'hE;
            SEG_F: nibble = 4'hF;
            default: begin
                nibble = 4'h0;
                ok     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seven_seg_rx.sv
// Seven-segment link receiver: deserializes 16-bit LSB-first frames framed
// by latch, splits them into segment/select bytes, decodes the digit and
// mirrors the two displayed digits in value.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_SYNC | discarding bits until latch=0 marks a frame end
//   ST_RUN  | aligned; shifting bits, checking latch against the bit count
module seven_seg_rx
    import seven_seg_pkg::*;
#(
    parameter logic [7:0] ONES_SEL = DEF_ONES_SEL,
    parameter logic [7:0] TENS_SEL = DEF_TENS_SEL
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_data,
    input  logic       latch,
    output logic       frame_valid,
    output logic [7:0] seg_pattern,
    output logic [7:0] digit_sel,
    output logic [3:0] nibble,
    output logic       nibble_ok,
    output logic       frame_err,
    output logic [7:0] value,
    output logic       synced
);

    rx_state_t   state;
    logic [3:0]  count;
    // Bit 0 of the shift register would only ever be shifted out, so it is
    // not stored; the full word is formed together with the incoming bit.
    logic [15:1] sr;
    logic [15:0] word_next;
    logic [3:0]  dec_nibble;
    logic        dec_ok;

    assign word_next = {in_data, sr[15:1]};

    seven_seg_decode u_decode (
        .pattern (word_next[15:8]),
        .nibble  (dec_nibble),
        .ok      (dec_ok)
    );

    // Framing FSM with registered frame fields, pulses and display mirror.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_SYNC;
            count       <= 4'd0;
            sr          <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            seg_pattern <= 8'h00;
            digit_sel   <= 8'h00;
            nibble      <= 4'h0;
            nibble_ok   <= 1'b0;
            value       <= 8'h00;
            synced      <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                ST_SYNC: begin
                    if (!latch) begin
                        state  <= ST_RUN;
                        count  <= 4'd0;
                        synced <= 1'b1;
                    end
                end
                ST_RUN: begin
                    sr    <= word_next[15:1];
                    count <= count + 4'd1;
                    if (count == FRAME_LAST) begin
                        count <= 4'd0;
                        if (!latch) begin
                            frame_valid <= 1'b1;
                            seg_pattern <= word_next[15:8];
                            digit_sel   <= word_next[7:0];
                            nibble      <= dec_nibble;
                            nibble_ok   <= dec_ok;
                            if (dec_ok) begin
                                if (word_next[7:0] == ONES_SEL) begin
                                    value[3:0] <= dec_nibble;
                                end else if (word_next[7:0] == TENS_SEL) begin
                                    value[7:4] <= dec_nibble;
                                end
                            end
                        end else begin
                            // Frame overran its length: alignment is lost.
                            frame_err <= 1'b1;
                            state     <= ST_SYNC;
                            synced    <= 1'b0;
                        end
                    end else if (!latch) begin
                        // Early frame end: realign on this edge.
                        frame_err <= 1'b1;
                        count     <= 4'd0;
                    end
                end
                default: begin
                    state  <= ST_SYNC;
                    synced <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_rx.sv
// Randomized self-checking bench for seven_seg_rx with a bit-queue protocol
// model and directed scenarios pinned by hand-computed values.
module tb_seven_seg_rx;

    localparam logic [7:0] ONES = 8'h40;
    localparam logic [7:0] TENS = 8'h20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_data = 1'b0;
    logic       latch = 1'b1;
    logic       frame_valid;
    logic [7:0] seg_pattern;
    logic [7:0] digit_sel;
    logic [3:0] nibble;
    logic       nibble_ok;
    logic       frame_err;
    logic [7:0] value;
    logic       synced;

    int tests = 0;
    int fails = 0;
    int fv_cnt = 0;
    int fe_cnt = 0;

    int unsigned seg_tab [16] = '{32'hEE, 32'h48, 32'h3E, 32'h7C,
                                  32'hD8, 32'hF4, 32'hF6, 32'h68,
                                  32'hFE, 32'hFC, 32'hFA, 32'hD6,
                                  32'hA6, 32'h5E, 32'hB6, 32'hB2};

    // Model state: aligned flag plus the bits collected in the current frame.
    bit         m_sync;
    bit         q[$];
    logic [7:0] e_seg, e_sel, e_val;
    logic [3:0] e_nib;
    logic       e_ok, e_fv, e_fe, e_syn;

    seven_seg_rx dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .latch       (latch),
        .frame_valid (frame_valid),
        .seg_pattern (seg_pattern),
        .digit_sel   (digit_sel),
        .nibble      (nibble),
        .nibble_ok   (nibble_ok),
        .frame_err   (frame_err),
        .value       (value),
        .synced      (synced)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sync = 1'b0;
        q.delete();
        e_seg = 8'h00; e_sel = 8'h00; e_val = 8'h00; e_nib = 4'h0;
        e_ok = 1'b0; e_fv = 1'b0; e_fe = 1'b0; e_syn = 1'b0;
    endtask

    task automatic model_good_frame();
        int unsigned w = 0;
        int unsigned seg, sel;
        for (int k = 0; k < 16; k++) w += int'(q[k]) << k;
        seg = w / 256;
        sel = w % 256;
        e_seg = 8'(seg);
        e_sel = 8'(sel);
        e_nib = 4'h0;
        e_ok  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg_tab[i] == seg) begin
                e_nib = 4'(i);
                e_ok  = 1'b1;
            end
        end
        if (e_ok) begin
            if (e_sel == ONES)      e_val = {e_val[7:4], e_nib};
            else if (e_sel == TENS) e_val = {e_nib, e_val[3:0]};
        end
        e_fv = 1'b1;
    endtask

    task automatic model_step(input bit d, input bit l);
        e_fv = 1'b0;
        e_fe = 1'b0;
        if (!m_sync) begin
            if (!l) begin
                m_sync = 1'b1;
                q.delete();
            end
        end else begin
            q.push_back(d);
            if (q.size() == 16) begin
                if (!l) begin
                    model_good_frame();
                end else begin
                    e_fe   = 1'b1;
                    m_sync = 1'b0;
                end
                q.delete();
            end else if (!l) begin
                e_fe = 1'b1;
                q.delete();
            end
        end
        e_syn = m_sync;
    endtask

    task automatic compare_all();
        chk("frame_valid", 32'(frame_valid), 32'(e_fv));
        chk("frame_err",   32'(frame_err),   32'(e_fe));
        chk("seg_pattern", 32'(seg_pattern), 32'(e_seg));
        chk("digit_sel",   32'(digit_sel),   32'(e_sel));
        chk("nibble",      32'(nibble),      32'(e_nib));
        chk("nibble_ok",   32'(nibble_ok),   32'(e_ok));
        chk("value",       32'(value),       32'(e_val));
        chk("synced",      32'(synced),      32'(e_syn));
        chk("fv_fe_excl",  32'(frame_valid & frame_err), 32'd0);
    endtask

    task automatic cycle(input bit d, input bit l);
        @(negedge clk);
        rst     = 1'b0;
        in_data = d;
        latch   = l;
        model_step(d, l);
        @(posedge clk);
        #1;
        compare_all();
        if (frame_valid) fv_cnt++;
        if (frame_err)   fe_cnt++;
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk);
        rst     = 1'b1;
        in_data = 1'b0;
        latch   = 1'b1;
        model_reset();
        #1;
        compare_all();
        chk("rst_value",  32'(value), 32'h0);
        chk("rst_seg",    32'(seg_pattern), 32'h0);
        chk("rst_synced", 32'(synced), 32'h0);
        repeat (n) begin
            @(posedge clk);
            #1;
            compare_all();
        end
    endtask

    task automatic send_frame(input logic [7:0] seg, input logic [7:0] sel);
        logic [15:0] w;
        w = {seg, sel};
        for (int k = 0; k < 16; k++) cycle(w[k], k != 15);
    endtask

    // n bits, latch low only on the last one.
    task automatic send_partial(input int n);
        for (int k = 0; k < n; k++) cycle(1'($urandom_range(0, 1)), k != n - 1);
    endtask

    task automatic send_high(input int n);
        for (int k = 0; k < n; k++) cycle(1'($urandom_range(0, 1)), 1'b1);
    endtask

    initial begin
        int base;
        logic [7:0] s, d;

        // Reset, alignment, first ones frame.
        apply_reset(2);
        send_high(3);
        send_partial(6);
        chk("align_no_fv", 32'(fv_cnt), 32'd0);
        send_frame(8'h48, 8'h40);
        chk("t1_fv",     32'(frame_valid), 32'd1);
        chk("t1_nibble", 32'(nibble), 32'd1);
        chk("t1_ok",     32'(nibble_ok), 32'd1);
        chk("t1_value",  32'(value), 32'h01);

        // Back-to-back ones/tens stream.
        base = fv_cnt;
        fe_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            send_frame(8'hFC, 8'h40);
            send_frame(8'hB2, 8'h20);
        end
        chk("t2_fv_count", 32'(fv_cnt - base), 32'd12);
        chk("t2_no_err",   32'(fe_cnt), 32'd0);
        chk("t2_value",    32'(value), 32'hF9);

        // Undecodable pattern is reported but leaves value alone.
        send_frame(8'h00, 8'h40);
        chk("t3_fv",    32'(frame_valid), 32'd1);
        chk("t3_ok",    32'(nibble_ok), 32'd0);
        chk("t3_nib",   32'(nibble), 32'd0);
        chk("t3_value", 32'(value), 32'hF9);

        // Early latch drop at bit 9, then an immediate good frame.
        send_partial(10);
        chk("t4_err", 32'(frame_err), 32'd1);
        chk("t4_syn", 32'(synced), 32'd1);
        send_frame(8'h7C, 8'h20);
        chk("t4_fv",    32'(frame_valid), 32'd1);
        chk("t4_nib",   32'(nibble), 32'd3);
        chk("t4_value", 32'(value), 32'h39);

        // Latch held high for 20 bits.
        send_high(16);
        chk("t5_err",    32'(frame_err), 32'd1);
        chk("t5_synced", 32'(synced), 32'd0);
        send_high(4);
        send_partial(1);
        chk("t5_resync", 32'(synced), 32'd1);
        send_frame(8'hD8, 8'h40);
        chk("t5_fv",    32'(frame_valid), 32'd1);
        chk("t5_value", 32'(value), 32'h34);

        // Reset at bit 7 of a frame.
        for (int k = 0; k < 7; k++) cycle(1'($urandom_range(0, 1)), 1'b1);
        apply_reset(1);
        chk("t6_value0", 32'(value), 32'h0);
        base = fv_cnt;
        send_frame(8'hEE, 8'h40);
        chk("t6_align_no_fv", 32'(fv_cnt - base), 32'd0);
        chk("t6_synced",      32'(synced), 32'd1);
        send_frame(8'h5E, 8'h20);
        chk("t6_fv",    32'(frame_valid), 32'd1);
        chk("t6_value", 32'(value), 32'hD0);

        // Randomized mix of good frames, framing faults, noise and resets.
        for (int it = 0; it < 400; it++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 55) begin
                if ($urandom_range(0, 9) != 0) s = 8'(seg_tab[$urandom_range(0, 15)]);
                else                           s = 8'($urandom_range(0, 255));
                case ($urandom_range(0, 2))
                    0: d = ONES;
                    1: d = TENS;
                    default: d = 8'($urandom_range(0, 255));
                endcase
                send_frame(s, d);
            end else if (r < 70) begin
                send_partial(int'($urandom_range(1, 15)));
            end else if (r < 80) begin
                send_high(int'($urandom_range(1, 20)));
            end else if (r < 97) begin
                repeat ($urandom_range(1, 8))
                    cycle(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
            end else begin
                apply_reset(int'($urandom_range(1, 3)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seven_seg_rx.md
# seven_seg_rx

Serial receiver for the seven-segment shift-register link: it deserializes the 16-bit LSB-first frames framed by `latch` and splits each frame into segment pattern and digit-select bytes. It decodes the segment pattern back to a hex nibble and keeps a mirror of the two displayed digits. It sits on the board-side end of the link, or in the bench as a protocol monitor for the seven-segment driver.

## Interface
- `ONES_SEL`, default 8'h40: digit-select byte addressing the ones digit.
- `TENS_SEL`, default 8'h20: digit-select byte addressing the tens digit.

Ports:
- `clk`  in  1: single clock; all sampling on posedge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_data`  in  1: serial data, one bit per clk.
- `latch`  in  1: high for frame bits 0..14, low on bit 15 (the last bit).
- `frame_valid`  out  1: one-cycle pulse, frame captured.
- `seg_pattern`  out  8: word[15:8] of the last good frame.
- `digit_sel`  out  8: word[7:0] of the last good frame.
- `nibble`  out  4: decoded value of `seg_pattern`.
- `nibble_ok`  out  1: `seg_pattern` matched the segment table.
- `frame_err`  out  1: one-cycle pulse, framing violation.
- `value`  out  8: {tens nibble, ones nibble} display mirror.
- `synced`  out  1: receiver is in RUN.

## Operation
- Frame: 16 bits; the bit sampled at in-frame count k goes to word[k]. The shift register is {in_data, sr[15:1]}.
- Segment table, nibble to pattern: 0 EE, 1 48, 2 3E, 3 7C, 4 D8, 5 F4, 6 F6, 7 68, 8 FE, 9 FC, A FA, B D6, C A6, D 5E, E B6, F B2.
- Any other pattern gives `nibble`=0 and `nibble_ok`=0.
- FSM states are SYNC and RUN.
- SYNC (reset state):
  - Discard bits until `latch`=0 is sampled.
  - On that sample, go to RUN with count=0. No frame is reported, because the alignment frame is partial.
- RUN:
  - Each cycle, shift `in_data` in and increment count (4-bit).
  - At count=15 with `latch`=0: complete frame. Register `seg_pattern`/`digit_sel`/`nibble`/`nibble_ok`, pulse `frame_valid`, and set count to 0.
  - At count=15 with `latch`=1: pulse `frame_err`, discard the frame, and go to SYNC.
  - At count<15 with `latch`=0: pulse `frame_err`, discard the frame, set count to 0, and stay in RUN (realign on this edge).
- `value` update happens only on a complete frame with `nibble_ok`=1:
  - `digit_sel`==`ONES_SEL` writes `value[3:0]`.
  - `digit_sel`==`TENS_SEL` writes `value[7:4]`.
  - Any other select leaves `value` unchanged, but the frame is still reported.
- A frame whose pattern fails to decode is still reported (`frame_valid`=1, `nibble_ok`=0).

## Timing
- Reset values: every output 0, state SYNC, count 0, shift register 0.
- Latency:
  - `frame_valid` and the registered fields update on the clk edge that samples bit 15, and are visible in the following cycle.
  - `value` updates on that same edge.
- Back-to-back frames (16 cycles each, no gap) are supported. Bit 0 of the next frame is sampled on the edge right after bit 15.
- `frame_valid` and `frame_err` are never high in the same cycle.
- `seg_pattern`, `digit_sel`, `nibble` and `nibble_ok` hold between frames.
- Reset mid-frame: immediate return to reset values. The first frame after reset is consumed for alignment.
- `latch` low for several consecutive cycles in RUN: each sample is a count<15 violation (`frame_err` each cycle) except the one landing at count=15.

## Structure
- Package `seven_seg_pkg` holds:
  - The 16 segment pattern constants.
  - Default ONES/TENS select constants, shared with the driver.
  - The FSM state enum.
  - Frame-length constant 16.
- Sub-module `seven_seg_decode`: combinational 8-bit pattern to {nibble, ok}. It is reused by the driver's self-check.

## Test plan
- Reset, a partial alignment frame, then ones frame 0x48_40 -> `frame_valid` pulse; `nibble`=1, `nibble_ok`=1, `value`=0x01.
- Continuous stream alternating ones 0xFC_40 and tens 0xB2_20 with no gaps -> `frame_valid` every 16 cycles; `value`=0xF9; no `frame_err`.
- Pattern 0x00 with select 0x40 -> `frame_valid`=1, `nibble_ok`=0; `value` unchanged.
- `latch` dropped at bit 9 -> `frame_err` pulse; a good frame starting the next cycle decodes correctly.
- `latch` held high for 20 bits -> `frame_err` at count 15, `synced`=0; recovery after the next `latch`=0.
- `rst` asserted at bit 7 of a frame -> all outputs 0 immediately; the next full frame is alignment-only with no `frame_valid`; the one after is reported.
